// File: rtl/lsu.sv
// Load/store unit between the execute stage and data memory: width selection, load extension.
// Define LSU_MISALIGN_EN to split misaligned accesses into stalled multi-cycle sequences.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign_fault,
  output logic        dmem_we,
  output logic [2:0]  dmem_funct3,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wd,
  input  logic [31:0] dmem_rd
);

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] f3);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'b0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2'b01:   r = f3[2] ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  logic        legal, is_load, is_store, misaligned;
  logic [31:0] aligned_word, rdata_al;

  // A store wins when both request lines are high.
  always_comb begin
    legal        = (funct3[1:0] != 2'b11) && (funct3[2:1] != 2'b11);
    is_store     = mem_write && legal;
    is_load      = mem_read && !mem_write && legal;
    misaligned   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    aligned_word = dmem_rd >> {addr[1:0], 3'b000};
    rdata_al     = is_load ? extend(aligned_word, funct3) : 32'h0;
  end

`ifdef LSU_MISALIGN_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD_HI = 2'd1, STORE_BYTE = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] lo_buf_q, lo_buf_d;
  logic        last_byte;
  logic [5:0]  sh;
  logic [31:0] hi_word, word_base;
  logic [7:0]  store_byte;

  assign last_byte = (funct3[1:0] == 2'b01) ? (k_q == 2'd1) : (k_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= 2'd0;
      lo_buf_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      lo_buf_q <= lo_buf_d;
    end
  end

  always_comb begin : next_state
    state_d  = state_q;
    k_d      = k_q;
    lo_buf_d = lo_buf_q;
    case (state_q)
      IDLE: begin
        if (is_store && misaligned) begin
          state_d = STORE_BYTE;
          k_d     = 2'd1;
        end else if (is_load && misaligned) begin
          state_d  = LOAD_HI;
          lo_buf_d = dmem_rd;
        end
      end
      LOAD_HI: state_d = IDLE;
      STORE_BYTE: begin
        if (last_byte) begin
          state_d = IDLE;
          k_d     = 2'd0;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = 2'd0;
      end
    endcase
  end

  always_comb begin : outputs
    rdata          = 32'h0;
    stall          = 1'b0;
    misalign_fault = 1'b0;
    dmem_we        = 1'b0;
    dmem_funct3    = 3'b000;
    dmem_addr      = 32'h0;
    dmem_wd        = 32'h0;
    word_base      = {addr[31:2], 2'b00};
    sh             = {1'b0, addr[1:0], 3'b000};
    // Upper word supplies the bytes that spill past the low word boundary.
    hi_word        = (dmem_rd << (6'd32 - sh)) | (lo_buf_q >> sh);
    case (k_q)
      2'd0:    store_byte = wdata[7:0];
      2'd1:    store_byte = wdata[15:8];
      2'd2:    store_byte = wdata[23:16];
      default: store_byte = wdata[31:24];
    endcase
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (is_store && misaligned) begin
            dmem_we   = 1'b1;
            dmem_addr = addr;
            dmem_wd   = {24'b0, store_byte};
            stall     = 1'b1;
          end else if (is_load && misaligned) begin
            dmem_funct3 = 3'b010;
            dmem_addr   = word_base;
            stall       = 1'b1;
          end else if (is_load || is_store) begin
            dmem_we     = is_store;
            dmem_funct3 = {1'b0, funct3[1:0]};
            dmem_addr   = addr;
            dmem_wd     = wdata;
            rdata       = rdata_al;
          end
        end
        LOAD_HI: begin
          dmem_funct3 = 3'b010;
          dmem_addr   = word_base + 32'd4;
          rdata       = extend(hi_word, funct3);
        end
        STORE_BYTE: begin
          dmem_we   = 1'b1;
          dmem_addr = addr + {30'b0, k_q};
          dmem_wd   = {24'b0, store_byte};
          stall     = !last_byte;
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_clk;
  assign unused_clk = clk;

  always_comb begin : outputs
    rdata          = 32'h0;
    stall          = 1'b0;
    misalign_fault = 1'b0;
    dmem_we        = 1'b0;
    dmem_funct3    = 3'b000;
    dmem_addr      = 32'h0;
    dmem_wd        = 32'h0;
    if (!rst && (is_load || is_store)) begin
      if (misaligned) begin
        misalign_fault = 1'b1;
      end else begin
        dmem_we     = is_store;
        dmem_funct3 = {1'b0, funct3[1:0]};
        dmem_addr   = addr;
        dmem_wd     = wdata;
        rdata       = rdata_al;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: byte-array data memory model, vector table for aligned traffic,
// hand sequences for misaligned splitting (or faulting) and reset mid-store.
module tb_lsu;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        stall, misalign_fault, dmem_we;
  logic [2:0]  dmem_funct3;
  logic [31:0] dmem_addr, dmem_wd, dmem_rd;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .misalign_fault(misalign_fault), .dmem_we(dmem_we), .dmem_funct3(dmem_funct3),
    .dmem_addr(dmem_addr), .dmem_wd(dmem_wd), .dmem_rd(dmem_rd)
  );

  // Data memory model: 64 bytes, little-endian, asynchronous word read.
  logic [7:0] mem [0:63];
  logic       preload_req;
  logic [5:0] rd_base, wa;
  assign rd_base = {dmem_addr[5:2], 2'b00};
  assign wa      = dmem_addr[5:0];
  assign dmem_rd = {mem[rd_base + 6'd3], mem[rd_base + 6'd2], mem[rd_base + 6'd1], mem[rd_base]};

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      {mem[3], mem[2], mem[1], mem[0]}   <= 32'h44332211;
      {mem[7], mem[6], mem[5], mem[4]}   <= 32'h88776655;
      {mem[11], mem[10], mem[9], mem[8]} <= 32'hCCBBAA99;
    end else if (dmem_we) begin
      mem[wa] <= dmem_wd[7:0];
      if (dmem_funct3 != 3'b000) mem[wa + 6'd1] <= dmem_wd[15:8];
      if (dmem_funct3 == 3'b010) begin
        mem[wa + 6'd2] <= dmem_wd[23:16];
        mem[wa + 6'd3] <= dmem_wd[31:24];
      end
    end
  end

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
  endfunction

  // Scoreboard
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_rdata(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: scoreboard empty, rdata 0x%08h", name, rdata);
    end else begin
      e = exp_q.pop_front();
      chk(name, rdata, e);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_read = r; mem_write = w; funct3 = f; addr = a; wdata = d;
    #1;
  endtask

  task automatic go_idle();
    drive(1'b0, 1'b0, LB, 32'h0, 32'h0);
  endtask

  task automatic do_preload();
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    logic        exp_we;
    logic        chk_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input logic ew, input logic ca);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd;
    v.exp_rdata = er; v.exp_we = ew; v.chk_addr = ca;
    return v;
  endfunction

`ifdef LSU_MISALIGN_EN
  task automatic mis_load(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] exp);
    logic [31:0] base;
    base = {a[31:2], 2'b00};
    drive(1'b1, 1'b0, f, a, 32'h0);
    chk({name, "_stall1"}, stall, 1'b1);
    chk({name, "_addr1"}, dmem_addr, base);
    exp_q.push_back(exp);
    @(negedge clk); #1;
    chk({name, "_stall2"}, stall, 1'b0);
    chk({name, "_addr2"}, dmem_addr, base + 32'd4);
    chk_rdata({name, "_rdata"});
    go_idle();
  endtask

  task automatic mis_store(input string name, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] d, input int n);
    logic [31:0] sh_d;
    for (int i = 0; i < n; i++) begin
      if (i == 0) drive(1'b0, 1'b1, f, a, d);
      else begin @(negedge clk); #1; end
      sh_d = d >> (8 * i);
      chk($sformatf("%s_stall%0d", name, i), stall, (i < n - 1) ? 1'b1 : 1'b0);
      chk($sformatf("%s_we%0d", name, i), dmem_we, 1'b1);
      chk($sformatf("%s_addr%0d", name, i), dmem_addr, a + i);
      chk($sformatf("%s_wd%0d", name, i), {24'b0, dmem_wd[7:0]}, {24'b0, sh_d[7:0]});
    end
    go_idle();
  endtask
`endif

  initial begin
    rst = 1'b1; preload_req = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; funct3 = LB; addr = 32'h0; wdata = 32'h0;
    @(negedge clk); @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_fault", misalign_fault, 1'b0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_f3", dmem_funct3, 3'b000);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wd", dmem_wd, 32'h0);
    rst = 1'b0; preload_req = 1'b0;

    vecs.push_back(mk(0, 0, LB,     32'h00, 32'h0,        32'h00000000, 0, 0));
    vecs.push_back(mk(1, 0, LB,     32'h03, 32'h0,        32'h00000044, 0, 1));
    vecs.push_back(mk(1, 0, LB,     32'h07, 32'h0,        32'hFFFFFF88, 0, 1));
    vecs.push_back(mk(1, 0, LBU,    32'h07, 32'h0,        32'h00000088, 0, 1));
    vecs.push_back(mk(1, 0, LH,     32'h06, 32'h0,        32'hFFFF8877, 0, 1));
    vecs.push_back(mk(1, 0, LHU,    32'h02, 32'h0,        32'h00004433, 0, 1));
    vecs.push_back(mk(1, 0, LW,     32'h08, 32'h0,        32'hCCBBAA99, 0, 1));
    vecs.push_back(mk(1, 0, LB,     32'h09, 32'h0,        32'hFFFFFFAA, 0, 1));
    vecs.push_back(mk(1, 0, 3'b011, 32'h00, 32'h0,        32'h00000000, 0, 0));
    vecs.push_back(mk(1, 0, 3'b110, 32'h04, 32'h0,        32'h00000000, 0, 0));
    vecs.push_back(mk(1, 1, LW,     32'h20, 32'hDEADBEEF, 32'h00000000, 1, 1));
    vecs.push_back(mk(1, 0, LW,     32'h20, 32'h0,        32'hDEADBEEF, 0, 1));
    vecs.push_back(mk(0, 1, LB,     32'h21, 32'h123456AB, 32'h00000000, 1, 1));
    vecs.push_back(mk(1, 0, LW,     32'h20, 32'h0,        32'hDEADABEF, 0, 1));
    vecs.push_back(mk(0, 1, 3'b111, 32'h24, 32'hFFFFFFFF, 32'h00000000, 0, 0));
    vecs.push_back(mk(1, 0, LW,     32'h24, 32'h0,        32'h00000000, 0, 1));
    vecs.push_back(mk(0, 1, LH,     32'h26, 32'hAAAA1234, 32'h00000000, 1, 1));
    vecs.push_back(mk(1, 0, LW,     32'h24, 32'h0,        32'h12340000, 0, 1));
    vecs.push_back(mk(1, 0, LHU,    32'h26, 32'h0,        32'h00001234, 0, 1));
    vecs.push_back(mk(1, 0, LBU,    32'h23, 32'h0,        32'h000000DE, 0, 1));

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp_rdata);
      drive(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].wd);
      chk_rdata($sformatf("vec%0d_rdata", i));
      chk($sformatf("vec%0d_stall", i), stall, 1'b0);
      chk($sformatf("vec%0d_fault", i), misalign_fault, 1'b0);
      chk($sformatf("vec%0d_we", i), dmem_we, vecs[i].exp_we);
      if (vecs[i].chk_addr) begin
        chk($sformatf("vec%0d_addr", i), dmem_addr, vecs[i].a);
        chk($sformatf("vec%0d_f3", i), dmem_funct3, {1'b0, vecs[i].f3[1:0]});
      end
    end
    go_idle();

`ifdef LSU_MISALIGN_EN
    mis_load("lw1", LW, 32'h1, 32'h55443322);
    mis_load("lh7", LH, 32'h7, 32'hFFFF9988);
    mis_load("lhu7", LHU, 32'h7, 32'h00009988);
    mis_load("lw_wrap", LW, 32'hFFFFFFFD, 32'h11000000);
    mis_store("sw5", LW, 32'h5, 32'h12345678, 4);
    chk("sw5_word4", mem_word(4), 32'h34567855);
    chk("sw5_word8", mem_word(8), 32'hCCBBAA12);
    mis_store("sh21", LH, 32'h21, 32'h0000BEEF, 2);
    chk("sh21_word20", mem_word(32), 32'hDEBEEFEF);

    // Reset lands on the third byte of a misaligned sw.
    do_preload();
    drive(1'b0, 1'b1, LW, 32'h5, 32'h12345678);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_we", dmem_we, 1'b0);
    @(negedge clk);
    rst = 1'b0; mem_write = 1'b0;
    #1;
    chk("rstmid_stall", stall, 1'b0);
    chk("rstmid_idle_we", dmem_we, 1'b0);
    chk("rstmid_b5", mem[5], 8'h78);
    chk("rstmid_b6", mem[6], 8'h56);
    chk("rstmid_b7", mem[7], 8'h88);
    exp_q.push_back(32'h88567855);
    drive(1'b1, 1'b0, LW, 32'h4, 32'h0);
    chk_rdata("rstmid_lw4");
    chk("rstmid_lw4_stall", stall, 1'b0);
    go_idle();
`else
    drive(1'b1, 1'b0, LW, 32'h2, 32'h0);
    chk("lw2_fault", misalign_fault, 1'b1);
    chk("lw2_rdata", rdata, 32'h0);
    chk("lw2_stall", stall, 1'b0);
    drive(1'b0, 1'b1, LW, 32'h2, 32'hFFFFFFFF);
    chk("sw2_fault", misalign_fault, 1'b1);
    chk("sw2_we", dmem_we, 1'b0);
    chk("sw2_stall", stall, 1'b0);
    drive(1'b1, 1'b0, LHU, 32'h1, 32'h0);
    chk("lhu1_fault", misalign_fault, 1'b1);
    chk("lhu1_rdata", rdata, 32'h0);
    go_idle();
    chk("sw2_word0", mem_word(0), 32'h44332211);
    chk("idle_fault", misalign_fault, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
